imem_dmem_arbiter: RTL and testbench

- Arbitrates the single unified memory port between the fetch stage and the data path.
- Fetch side: read-only, with a redirect abort. Data side: load/store.
- Sequences each transaction through a small FSM, registers responses and generates the ihit/dhit pulses consumed by fetch and memory stages.
- Data has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/imem_dmem_arbiter_if.sv | 37 +++
 rtl/imem_dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - fetch, data and memory-port signal bundle for the arbiter
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iabort;
  logic              ihit;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  iREN, iaddr, iabort, dREN, dWEN, daddr, dstore, mem_rdata, mem_ready,
    output ihit, iload, dhit, dload, mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );

  modport master (
    output iREN, iaddr, iabort, dREN, dWEN, daddr, dstore, mem_rdata, mem_ready,
    input  ihit, iload, dhit, dload, mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - unified memory port arbiter, data priority with fetch anti-starvation
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  imem_dmem_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_e;

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                drop_q, drop_d;
  logic                mem_ren_q, mem_ren_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   iload_q, iload_d;
  logic [DATA_W-1:0]   dload_q, dload_d;
  logic                d_req;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    d_req       = bus.dREN | bus.dWEN;

    case (state_q)
      IDLE: begin
        if (!bus.iREN) starve_d = '0;
        if (d_req && (!bus.iREN || starve_q < LIMIT)) begin
          state_d     = DACC;
          mem_wen_d   = bus.dWEN;
          mem_ren_d   = ~bus.dWEN;
          mem_addr_d  = bus.daddr;
          mem_wdata_d = bus.dstore;
          // Grant with iREN high implies starve_q < LIMIT, so this saturates at LIMIT
          if (bus.iREN) starve_d = starve_q + 1'b1;
        end else if (bus.iREN && !bus.iabort) begin
          state_d    = IACC;
          mem_ren_d  = 1'b1;
          mem_wen_d  = 1'b0;
          mem_addr_d = bus.iaddr;
          starve_d   = '0;
        end
      end
      IACC: begin
        if (bus.iabort) drop_d = 1'b1;
        if (bus.mem_ready) begin
          state_d   = IRESP;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (!drop_q && !bus.iabort) iload_d = bus.mem_rdata;
        end
      end
      DACC: begin
        if (bus.mem_ready) begin
          state_d   = DRESP;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (!mem_wen_q) dload_d = bus.mem_rdata;
        end
      end
      IRESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      DRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
    end
  end

  // A redirect arriving during the response cycle still kills the pulse
  assign bus.ihit      = (state_q == IRESP) && !drop_q && !bus.iabort;
  assign bus.dhit      = (state_q == DRESP);
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.iREN = 0; bus.iaddr = '0; bus.iabort = 0;
    bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
  endtask

  logic [DW-1:0] mem_arr [128];
  logic [DW-1:0] shadow  [128];
  byte           exp_seq [10];
  byte           got_g;
  int            ng, n_ih, n_dh, i_wait, d_wait, cnt_d, idx;
  bit            any_ihit, ireq_p, dreq_p, strobe_p, strobe, exp_d, got_d;

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    check_eq("rst_strobes", {bus.mem_ren, bus.mem_wen, bus.busy, bus.ihit, bus.dhit}, 0);
    check_eq("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
    check_eq("rst_loads", {bus.iload, bus.dload}, 0);
    rst = 0;

    // single fetch, zero wait
    bus.iREN = 1; bus.iaddr = 32'h100;
    step();
    check_eq("f1_ren", bus.mem_ren, 1);
    check_eq("f1_addr", bus.mem_addr, 32'h100);
    check_eq("f1_busy", bus.busy, 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    check_eq("f1_ihit", bus.ihit, 1);
    check_eq("f1_iload", bus.iload, 32'hDEADBEEF);
    check_eq("f1_ren_drop", bus.mem_ren, 0);
    bus.iREN = 0; bus.mem_ready = 0;
    step();
    check_eq("f1_idle", {bus.busy, bus.ihit}, 0);

    // store with three wait cycles, then load it back
    bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'h12345678;
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("st_wen_c%0d", k), {bus.mem_wen, bus.mem_ren}, 2'b10);
      check_eq($sformatf("st_addr_c%0d", k), {bus.mem_addr, bus.mem_wdata}, {32'h40, 32'h12345678});
      check_eq($sformatf("st_nohit_c%0d", k), bus.dhit, 0);
      bus.mem_ready = (k == 3);
      step();
    end
    check_eq("st_dhit", bus.dhit, 1);
    check_eq("st_wen_drop", bus.mem_wen, 0);
    bus.dWEN = 0; bus.mem_ready = 0;
    step();
    check_eq("st_dhit_once", bus.dhit, 0);
    bus.dREN = 1;
    step();
    check_eq("ld_strobes", {bus.mem_wen, bus.mem_ren}, 2'b01);
    bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
    step();
    check_eq("ld_dhit", bus.dhit, 1);
    check_eq("ld_dload", bus.dload, 32'h12345678);
    bus.dREN = 0; bus.mem_ready = 0;
    step();

    // both channels hammering a zero-wait memory
    exp_seq = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    bus.iREN = 1; bus.iaddr = 32'h1000;
    bus.dREN = 1; bus.daddr = 32'h2000;
    bus.mem_rdata = 32'h5A5A5A5A;
    ng = 0;
    for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
      step();
      if (bus.mem_ren || bus.mem_wen) begin
        got_g = (bus.mem_addr == 32'h1000) ? "I" : "D";
        check_eq($sformatf("starve_grant%0d", ng), got_g, exp_seq[ng]);
        ng++;
        bus.mem_ready = 1;
      end else begin
        bus.mem_ready = 0;
      end
    end
    check_eq("starve_count", ng, 10);
    bus.iREN = 0; bus.dREN = 0;
    step();
    bus.mem_ready = 0;
    step(); step();

    // fetch aborted while waiting on memory
    bus.iREN = 1; bus.iaddr = 32'h200;
    any_ihit = 0;
    step();
    check_eq("ab_addr", {bus.mem_ren, bus.mem_addr}, {1'b1, 32'h200});
    bus.iabort = 1; bus.iREN = 0;
    step();
    any_ihit |= bus.ihit;
    check_eq("ab_hold", {bus.mem_ren, bus.mem_addr}, {1'b1, 32'h200});
    bus.iabort = 0;
    step();
    any_ihit |= bus.ihit;
    check_eq("ab_hold2", bus.mem_ren, 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0BAD0;
    step();
    any_ihit |= bus.ihit;
    check_eq("ab_resp_busy", {bus.busy, bus.mem_ren}, 2'b10);
    check_eq("ab_iload_kept", bus.iload, 32'h5A5A5A5A);
    bus.mem_ready = 0;
    step();
    any_ihit |= bus.ihit;
    check_eq("ab_no_ihit", any_ihit, 0);
    check_eq("ab_idle", bus.busy, 0);
    bus.iREN = 1; bus.iaddr = 32'h300;
    step();
    check_eq("ab_next_addr", {bus.mem_ren, bus.mem_addr}, {1'b1, 32'h300});
    bus.mem_ready = 1; bus.mem_rdata = 32'h0300C0DE;
    step();
    check_eq("ab_next_hit", {bus.ihit, bus.iload}, {1'b1, 32'h0300C0DE});
    bus.iREN = 0; bus.mem_ready = 0;
    step();

    // reset in the middle of a write
    bus.dWEN = 1; bus.daddr = 32'h44; bus.dstore = 32'h11;
    step();
    check_eq("rm_wen", bus.mem_wen, 1);
    rst = 1;
    step();
    check_eq("rm_outputs", {bus.mem_ren, bus.mem_wen, bus.busy, bus.dhit, bus.ihit}, 0);
    check_eq("rm_addr", {bus.mem_addr, bus.mem_wdata, bus.dload}, 0);
    rst = 0;
    step();
    check_eq("rm_regrant", {bus.mem_wen, bus.mem_addr}, {1'b1, 32'h44});
    bus.mem_ready = 1;
    step();
    check_eq("rm_dhit", bus.dhit, 1);
    bus.dWEN = 0; bus.mem_ready = 0;
    step();

    // read and write together behave as a write
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h77;
    step();
    check_eq("rw_strobes", {bus.mem_wen, bus.mem_ren, bus.mem_addr}, {2'b10, 32'h80});
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF0000;
    step();
    check_eq("rw_dhit", bus.dhit, 1);
    check_eq("rw_dload_kept", bus.dload, 32'h0);
    bus.dREN = 0; bus.dWEN = 0; bus.mem_ready = 0;
    step();
    check_eq("rw_dhit_once", bus.dhit, 0);

    // randomized traffic: fetch region at 0x100+, data region at 0x000+
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = $urandom;
      shadow[i]  = mem_arr[i];
    end
    clear_inputs();
    cnt_d = 0; strobe_p = 0; n_ih = 0; n_dh = 0; i_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ireq_p = bus.iREN;
      dreq_p = bus.dREN | bus.dWEN;
      step();
      strobe = bus.mem_ren | bus.mem_wen;
      if (strobe && !strobe_p) begin
        exp_d = dreq_p && (!ireq_p || cnt_d < LIMIT);
        got_d = ~bus.mem_addr[8];
        check_eq("rnd_grant_kind", got_d, exp_d);
        if (exp_d) begin
          check_eq("rnd_d_addr", bus.mem_addr, bus.daddr);
          check_eq("rnd_d_op", bus.mem_wen, bus.dWEN);
          if (bus.dWEN) check_eq("rnd_d_wdata", bus.mem_wdata, bus.dstore);
          cnt_d = ireq_p ? cnt_d + 1 : 0;
        end else begin
          check_eq("rnd_i_addr", bus.mem_addr, bus.iaddr);
          cnt_d = 0;
        end
      end
      strobe_p = strobe;

      if (bus.ihit) begin
        n_ih++;
        check_eq("rnd_ihit_req", bus.iREN, 1);
        check_eq("rnd_iload", bus.iload, mem_arr[bus.iaddr[8:2]]);
        bus.iREN = 0; i_wait = 0;
      end
      if (bus.dhit) begin
        n_dh++;
        check_eq("rnd_dhit_req", bus.dREN | bus.dWEN, 1);
        if (bus.dWEN) shadow[bus.daddr[8:2]] = bus.dstore;
        else check_eq("rnd_dload", bus.dload, shadow[bus.daddr[8:2]]);
        bus.dREN = 0; bus.dWEN = 0; d_wait = 0;
      end

      if (strobe) begin
        idx = int'(bus.mem_addr[8:2]);
        bus.mem_ready = ($urandom_range(0, 2) == 0);
        bus.mem_rdata = bus.mem_ready ? mem_arr[idx] : DW'($urandom);
        if (bus.mem_ready && bus.mem_wen) mem_arr[idx] = bus.mem_wdata;
      end else begin
        bus.mem_ready = 0;
      end

      if (bus.iREN) i_wait++;
      else if ($urandom_range(0, 2) == 0) begin
        bus.iREN  = 1;
        bus.iaddr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      end
      if (bus.dREN || bus.dWEN) d_wait++;
      else if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin bus.dREN = 1; bus.dWEN = 0; end
          2:       begin bus.dREN = 0; bus.dWEN = 1; end
          default: begin bus.dREN = 1; bus.dWEN = 1; end
        endcase
        bus.daddr  = 32'($urandom_range(0, 15)) * 4;
        bus.dstore = $urandom;
      end
      if (i_wait > 300) begin
        check_eq("rnd_ifetch_wait", i_wait, 300);
        bus.iREN = 0; i_wait = 0;
      end
      if (d_wait > 300) begin
        check_eq("rnd_data_wait", d_wait, 300);
        bus.dREN = 0; bus.dWEN = 0; d_wait = 0;
      end
    end
    check_eq("rnd_progress", (n_ih > 20) && (n_dh > 20), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
